// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel memory responder.
package falafel_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] MEM_ERR_WORD = '1;

    // Wide enough for the full LATENCY range of 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } resp_state_e;

endpackage

// File: rtl/falafel_mem_responder.sv
// Single-outstanding memory responder: read / write / CAS with fixed response latency.
// Optional macro FALAFEL_MEM_BOUNDS_CHECK_EN rejects out-of-range word indices with MEM_ERR_WORD.
module falafel_mem_responder
    import falafel_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    input  logic [DATA_W-1:0] mem_req_cas_exp_i,
    output logic              mem_resp_val_o,
    input  logic              mem_resp_rdy_i,
    output logic [DATA_W-1:0] mem_resp_data_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int OFF_W = $clog2(DATA_W / 8);

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [DATA_W-1:0] word_full;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] op_resp;
    logic              unused_addr_bits;

    assign word_full = mem_req_addr_i >> OFF_W;
    assign idx       = word_full[IDX_W-1:0];
    assign accept    = mem_req_val_i && (state_q == ST_IDLE);
    assign old_word  = mem_q[idx];

`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
    assign in_range = (word_full[DATA_W-1:IDX_W] == '0);
`else
    assign in_range = 1'b1;
`endif

    // Byte-offset bits never select anything; upper index bits only matter with bounds checking.
    assign unused_addr_bits = ^{mem_req_addr_i[OFF_W-1:0], word_full[DATA_W-1:IDX_W]};

    always_comb begin
        wr_en   = 1'b0;
        op_resp = old_word;
        if (mem_req_is_write_i) begin
            if (mem_req_is_cas_i) begin
                wr_en   = (old_word == mem_req_cas_exp_i);
                op_resp = old_word;
            end else begin
                wr_en   = 1'b1;
                op_resp = mem_req_data_i;
            end
        end
        if (!in_range) begin
            wr_en   = 1'b0;
            op_resp = MEM_ERR_WORD;
        end
    end

    // Array is cleared on reset, so a write committed before a mid-flight reset is lost too.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (accept && wr_en) begin
            mem_q[idx] <= mem_req_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rdata_d         = rdata_q;
        mem_req_rdy_o   = 1'b0;
        mem_resp_val_o  = 1'b0;
        mem_resp_data_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                mem_req_rdy_o = 1'b1;
                if (mem_req_val_i) begin
                    rdata_d = op_resp;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                mem_resp_val_o  = 1'b1;
                mem_resp_data_o = rdata_q;
                if (mem_resp_rdy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
